// File: rtl/control_idle_fsm.sv
// control_idle_fsm: IDLE/ACTIVE/ERROR/configuration controller for the 4-lane
// recirculation datapath. idle_out steers the recirculator selector, and pausa
// applies hysteresis flow control back toward the lane source.
// Optional build macro: IDLE_CNT_EN. When it is defined, ACTIVE only falls back
// to IDLE after IDLE_HOLD consecutive all-empty cycles instead of the first one.
module control_idle_fsm #(
   parameter int ADDR_W    = 2,
   parameter int IDLE_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [ADDR_W:0]   umbral_bajo_in,
   input  logic [ADDR_W:0]   umbral_alto_in,
   input  logic [3:0]        fifo_empty,
   input  logic [ADDR_W:0]   ocup0,
   input  logic [ADDR_W:0]   ocup1,
   input  logic [ADDR_W:0]   ocup2,
   input  logic [ADDR_W:0]   ocup3,
   input  logic [3:0]        fifo_err,
   output logic              idle_out,
   output logic              active_out,
   output logic              error_out,
   output logic [2:0]        estado,
   output logic [3:0]        err_lane,
   output logic              pausa,
   output logic [ADDR_W:0]   umbral_bajo,
   output logic [ADDR_W:0]   umbral_alto
);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   // The hold count must fit the 4-bit run counter and be at least one cycle.
   if (IDLE_HOLD < 1 || IDLE_HOLD > 15) begin : g_bad_idle_hold
      $error("control_idle_fsm: IDLE_HOLD must be in 1..15");
   end

   state_t state;
   state_t state_nxt;
   logic   pausa_nxt;
   logic   any_err;
   logic   all_empty;
   logic   any_high;
   logic   all_low;
   logic   run_state;

`ifdef IDLE_CNT_EN
   localparam logic [3:0] HOLD_LAST = 4'(IDLE_HOLD - 1);
   logic [3:0] idle_cnt;
   logic [3:0] idle_cnt_nxt;
`endif

   assign estado = state;

   // Lane condition summaries shared by the state and pause decisions.
   always_comb begin
      any_err   = |fifo_err;
      all_empty = (fifo_empty == 4'hF);
      any_high  = (ocup0 >= umbral_alto) || (ocup1 >= umbral_alto) ||
                  (ocup2 >= umbral_alto) || (ocup3 >= umbral_alto);
      all_low   = (ocup0 <= umbral_bajo) && (ocup1 <= umbral_bajo) &&
                  (ocup2 <= umbral_bajo) && (ocup3 <= umbral_bajo);
   end

   // Next-state selection; error beats init, init beats lane occupancy.
   always_comb begin
      state_nxt = state;
`ifdef IDLE_CNT_EN
      idle_cnt_nxt = 4'd0;
`endif
      case (state)
         ST_RESET: state_nxt = ST_INIT;
         ST_INIT: begin
            if (!init)
               state_nxt = (umbral_bajo > umbral_alto) ? ST_ERROR : ST_IDLE;
         end
         ST_IDLE: begin
            if (any_err)
               state_nxt = ST_ERROR;
            else if (init)
               state_nxt = ST_INIT;
            else if (!all_empty)
               state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (any_err)
               state_nxt = ST_ERROR;
            else if (init)
               state_nxt = ST_INIT;
            else if (all_empty) begin
`ifdef IDLE_CNT_EN
               if (idle_cnt == HOLD_LAST)
                  state_nxt = ST_IDLE;
               else
                  idle_cnt_nxt = idle_cnt + 4'd1;
`else
               state_nxt = ST_IDLE;
`endif
            end
         end
         ST_ERROR: state_nxt = ST_ERROR;
         default:  state_nxt = ST_RESET;
      endcase
   end

   // Pause hysteresis, judged against the state being entered so that
   // RESET/INIT/ERROR always present pausa low.
   always_comb begin
      run_state = (state_nxt == ST_IDLE) || (state_nxt == ST_ACTIVE);
      pausa_nxt = 1'b0;
      if (run_state) begin
         if (any_high)
            pausa_nxt = 1'b1;
         else if (all_low)
            pausa_nxt = 1'b0;
         else
            pausa_nxt = pausa;
      end
   end

   // State register with registered decodes, threshold capture and error lanes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RESET;
         idle_out    <= 1'b0;
         active_out  <= 1'b0;
         error_out   <= 1'b0;
         err_lane    <= 4'd0;
         pausa       <= 1'b0;
         umbral_bajo <= '0;
         umbral_alto <= '0;
`ifdef IDLE_CNT_EN
         idle_cnt    <= 4'd0;
`endif
      end else begin
         state      <= state_nxt;
         idle_out   <= (state_nxt == ST_IDLE);
         active_out <= (state_nxt == ST_ACTIVE);
         error_out  <= (state_nxt == ST_ERROR);
         pausa      <= pausa_nxt;
`ifdef IDLE_CNT_EN
         idle_cnt   <= idle_cnt_nxt;
`endif
         if (state == ST_INIT && init) begin
            umbral_bajo <= umbral_bajo_in;
            umbral_alto <= umbral_alto_in;
         end
         if ((state == ST_IDLE || state == ST_ACTIVE) && any_err)
            err_lane <= err_lane | fifo_err;
      end
   end

endmodule

// File: tb/tb_control_idle_fsm.sv
// tb_control_idle_fsm: directed walk through the controller's main scenarios
// followed by a randomized run, all checked against a behavioural model that
// reasons in terms of state numbers, the largest lane occupancy and a run
// length of empty cycles. Honors IDLE_CNT_EN when it is defined.
module tb_control_idle_fsm;

   localparam int ADDR_W = 2;
   localparam int MAXOCC = 2 ** ADDR_W;
`ifdef IDLE_CNT_EN
   localparam int HOLD = 4;
`else
   localparam int HOLD = 1;
`endif

   logic              clk;
   logic              reset;
   logic              init;
   logic [ADDR_W:0]   bajoIn;
   logic [ADDR_W:0]   altoIn;
   logic [3:0]        fifoEmpty;
   logic [ADDR_W:0]   ocup [4];
   logic [3:0]        fifoErr;
   logic              idleOut;
   logic              activeOut;
   logic              errorOut;
   logic [2:0]        estado;
   logic [3:0]        errLane;
   logic              pausa;
   logic [ADDR_W:0]   umbralBajo;
   logic [ADDR_W:0]   umbralAlto;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int              mState;
   int              mBajo;
   int              mAlto;
   logic [3:0]      mErrLane;
   bit              mPausa;
   int              mEmptyRun;

   control_idle_fsm #(.ADDR_W(ADDR_W), .IDLE_HOLD(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .init           (init),
      .umbral_bajo_in (bajoIn),
      .umbral_alto_in (altoIn),
      .fifo_empty     (fifoEmpty),
      .ocup0          (ocup[0]),
      .ocup1          (ocup[1]),
      .ocup2          (ocup[2]),
      .ocup3          (ocup[3]),
      .fifo_err       (fifoErr),
      .idle_out       (idleOut),
      .active_out     (activeOut),
      .error_out      (errorOut),
      .estado         (estado),
      .err_lane       (errLane),
      .pausa          (pausa),
      .umbral_bajo    (umbralBajo),
      .umbral_alto    (umbralAlto)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic modelStep();
      int nxt;
      int maxOcc;
      if (reset) begin
         mState    = 0;
         mBajo     = 0;
         mAlto     = 0;
         mErrLane  = 4'd0;
         mPausa    = 1'b0;
         mEmptyRun = 0;
         return;
      end
      nxt = mState;
      if (mState == 0) begin
         nxt = 1;
      end else if (mState == 1) begin
         if (init) begin
            mBajo = int'(bajoIn);
            mAlto = int'(altoIn);
         end else begin
            nxt = (mBajo > mAlto) ? 4 : 2;
         end
      end else if (mState == 2 || mState == 3) begin
         if (fifoErr != 4'd0) begin
            mErrLane = mErrLane | fifoErr;
            nxt = 4;
         end else if (init) begin
            nxt = 1;
         end else if (mState == 2) begin
            if (fifoEmpty != 4'hF) nxt = 3;
         end else if (fifoEmpty == 4'hF) begin
            mEmptyRun++;
            if (mEmptyRun >= HOLD) nxt = 2;
         end
      end
      if (!(mState == 3 && nxt == 3 && fifoEmpty == 4'hF)) mEmptyRun = 0;
      maxOcc = 0;
      for (int i = 0; i < 4; i++)
         if (int'(ocup[i]) > maxOcc) maxOcc = int'(ocup[i]);
      if (nxt == 2 || nxt == 3) begin
         if (maxOcc >= mAlto)      mPausa = 1'b1;
         else if (maxOcc <= mBajo) mPausa = 1'b0;
      end else begin
         mPausa = 1'b0;
      end
      mState = nxt;
   endtask

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic checkModel();
      checkOutput("estado",      8'(estado),     8'(mState));
      checkOutput("idle_out",    8'(idleOut),    8'(mState == 2));
      checkOutput("active_out",  8'(activeOut),  8'(mState == 3));
      checkOutput("error_out",   8'(errorOut),   8'(mState == 4));
      checkOutput("err_lane",    8'(errLane),    8'(mErrLane));
      checkOutput("pausa",       8'(pausa),      8'(mPausa));
      checkOutput("umbral_bajo", 8'(umbralBajo), 8'(mBajo));
      checkOutput("umbral_alto", 8'(umbralAlto), 8'(mAlto));
   endtask

   // Apply one cycle of inputs, clock it, and check all outputs after the edge.
   task automatic applyStimulus(input bit r, input bit in, input int bajo, input int alto,
                                input logic [3:0] empty, input logic [3:0] err,
                                input int o0, input int o1, input int o2, input int o3);
      reset     = r;
      init      = in;
      bajoIn    = (ADDR_W + 1)'(bajo);
      altoIn    = (ADDR_W + 1)'(alto);
      fifoEmpty = empty;
      fifoErr   = err;
      ocup[0]   = (ADDR_W + 1)'(o0);
      ocup[1]   = (ADDR_W + 1)'(o1);
      ocup[2]   = (ADDR_W + 1)'(o2);
      ocup[3]   = (ADDR_W + 1)'(o3);
      modelStep();
      @(posedge clk);
      #1;
      checkModel();
   endtask

   // Directed scenarios, then randomized traffic, then the summary.
   initial begin
      mState = 0; mBajo = 0; mAlto = 0; mErrLane = 4'd0; mPausa = 1'b0; mEmptyRun = 0;

      // Reset held, then released into INIT.
      applyStimulus(1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
      checkOutput("rst_estado", 8'(estado), 8'd0);
      checkOutput("rst_idle",   8'(idleOut), 8'd0);
      applyStimulus(0, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
      checkOutput("init_estado", 8'(estado), 8'd1);

      // Threshold capture and entry into IDLE.
      applyStimulus(0, 1, 1, 3, 4'hF, 4'h0, 0, 0, 0, 0);
      checkOutput("cap_bajo", 8'(umbralBajo), 8'd1);
      checkOutput("cap_alto", 8'(umbralAlto), 8'd3);
      applyStimulus(0, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
      checkOutput("idle_estado", 8'(estado), 8'd2);
      checkOutput("idle_flag",   8'(idleOut), 8'd1);

      // IDLE -> ACTIVE -> IDLE.
      applyStimulus(0, 0, 0, 0, 4'b1110, 4'h0, 0, 0, 0, 0);
      checkOutput("active_estado", 8'(estado), 8'd3);
      checkOutput("active_flag",   8'(activeOut), 8'd1);
      for (int i = 1; i < HOLD; i++) begin
         applyStimulus(0, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
         checkOutput("hold_active", 8'(estado), 8'd3);
      end
      applyStimulus(0, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
      checkOutput("back_idle", 8'(estado), 8'd2);

      // Pause hysteresis with bajo=1, alto=3.
      applyStimulus(0, 0, 0, 0, 4'b1110, 4'h0, 0, 0, 3, 0);
      checkOutput("pausa_set", 8'(pausa), 8'd1);
      applyStimulus(0, 0, 0, 0, 4'b1110, 4'h0, 0, 0, 2, 0);
      checkOutput("pausa_hold", 8'(pausa), 8'd1);
      applyStimulus(0, 0, 0, 0, 4'b1110, 4'h0, 1, 1, 1, 0);
      checkOutput("pausa_clr", 8'(pausa), 8'd0);

      // Error beats init; ERROR is sticky until reset.
      applyStimulus(0, 1, 0, 0, 4'b1110, 4'b0100, 1, 1, 3, 1);
      checkOutput("err_estado", 8'(estado), 8'd4);
      checkOutput("err_lane",   8'(errLane), 8'h4);
      checkOutput("err_flag",   8'(errorOut), 8'd1);
      checkOutput("err_pausa",  8'(pausa), 8'd0);
      applyStimulus(0, 1, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
      checkOutput("err_sticky", 8'(estado), 8'd4);
      applyStimulus(1, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
      checkOutput("err_reset", 8'(estado), 8'd0);

      // Inverted thresholds go straight to ERROR with no lane flagged.
      applyStimulus(0, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
      applyStimulus(0, 1, 3, 2, 4'hF, 4'h0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 4'hF, 4'h0, 0, 0, 0, 0);
      checkOutput("badthr_estado", 8'(estado), 8'd4);
      checkOutput("badthr_lane",   8'(errLane), 8'h0);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         bit          r;
         bit          in;
         logic [3:0]  empty;
         logic [3:0]  err;
         r     = ($urandom_range(0, 39) == 0);
         in    = ($urandom_range(0, 7) == 0);
         empty = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         err   = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         applyStimulus(r, in,
                       int'($urandom_range(0, MAXOCC)), int'($urandom_range(0, MAXOCC)),
                       empty, err,
                       int'($urandom_range(0, MAXOCC)), int'($urandom_range(0, MAXOCC)),
                       int'($urandom_range(0, MAXOCC)), int'($urandom_range(0, MAXOCC)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
